// File: rtl/seq_instruction_decoder_if.sv
// Instruction handshake and datapath control bundle for seq_instruction_decoder.
// slave is the decoder side; master is the program source / datapath side.
interface seq_instruction_decoder_if #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ARGW = 4,
  parameter int unsigned NREG = 2
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic [OPW+ARGW-1:0]  instr;
  logic                 clear;
  logic [NREG-1:0]      en_reg;
  logic [ARGW-1:0]      alu_sel;
  logic                 en_out;
  logic                 busy;
  logic                 halted;
  logic                 err;

  modport master (
    output instr_valid, instr,
    input  instr_ready, clear, en_reg, alu_sel, en_out, busy, halted, err
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, clear, en_reg, alu_sel, en_out, busy, halted, err
  );
endinterface

// File: rtl/seq_instruction_decoder.sv
// Multi-cycle TinyCPU instruction decoder: latches instructions into ir and
// sequences datapath controls, with a repeat prefix, HALT and sticky err flag.
module seq_instruction_decoder #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ARGW = 4,
  parameter int unsigned NREG = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_instruction_decoder_if.slave bus
);
  localparam int unsigned IW = OPW + ARGW;

  localparam logic [OPW-1:0] OP_CLR     = OPW'(1);
  localparam logic [OPW-1:0] OP_LOAD    = OPW'(2);
  localparam logic [OPW-1:0] OP_ALU     = OPW'(3);
  localparam logic [OPW-1:0] OP_REP     = OPW'(4);
  localparam logic [OPW-1:0] OP_HALT    = OPW'(5);
  localparam logic [OPW-1:0] OP_ILL_MIN = OPW'(6);

  typedef enum logic [1:0] {IDLE, EXEC, OUT, HALTED} state_t;

  state_t          state, stateNext;
  logic [IW-1:0]   ir, irNext;
  logic [ARGW-1:0] repCnt, repCntNext;
  logic            repArmed, repArmedNext;
  logic            errQ, errNext;
  logic            lastCycle;
  logic [OPW-1:0]  opCur, opNext;
  logic [ARGW-1:0] argCur, argNext;

  logic            clearQ, clearNext;
  logic [NREG-1:0] enRegQ, enRegNext;
  logic [ARGW-1:0] aluSelQ, aluSelNext;
  logic            enOutQ, enOutNext;
  logic            readyQ, readyNext;
  logic            busyQ, busyNext;
  logic            haltedQ, haltedNext;

  assign opCur  = ir[IW-1:ARGW];
  assign argCur = ir[ARGW-1:0];

  // LOAD to a register that does not exist is flagged like an undefined opcode
  function automatic logic isIllegal(input logic [OPW-1:0] op, input logic [ARGW-1:0] arg);
    return (op >= OP_ILL_MIN) || ((op == OP_LOAD) && (32'(arg) >= NREG));
  endfunction

  always_comb begin
    stateNext    = state;
    irNext       = ir;
    repCntNext   = repCnt;
    repArmedNext = repArmed;
    errNext      = errQ;
    lastCycle    = 1'b0;
    opNext       = '0;
    argNext      = '0;
    clearNext    = 1'b0;
    enRegNext    = '0;
    aluSelNext   = '0;
    enOutNext    = 1'b0;
    readyNext    = 1'b0;
    busyNext     = 1'b0;
    haltedNext   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.instr_valid) begin
          irNext    = bus.instr;
          stateNext = EXEC;
        end
      end
      EXEC: begin
        if (isIllegal(opCur, argCur)) errNext = 1'b1;
        if (opCur == OP_HALT) begin
          stateNext    = HALTED;
          repArmedNext = 1'b0;
          repCntNext   = '0;
        end else if (opCur == OP_REP) begin
          repCntNext   = argCur;
          repArmedNext = 1'b1;
          stateNext    = IDLE;
        end else if (opCur == OP_ALU) begin
          stateNext = OUT;
        end else begin
          lastCycle = 1'b1;
        end
      end
      OUT:     lastCycle = 1'b1;
      HALTED:  stateNext = HALTED;
      default: stateNext = IDLE;
    endcase

    // End of an instruction: either re-run it under the repeat prefix or retire
    if (lastCycle) begin
      if (repArmed && (repCnt != '0)) begin
        repCntNext = repCnt - ARGW'(1);
        stateNext  = EXEC;
      end else begin
        repArmedNext = 1'b0;
        stateNext    = IDLE;
      end
    end

    // Outputs are registered, so decode them from the state being entered
    opNext  = irNext[IW-1:ARGW];
    argNext = irNext[ARGW-1:0];
    case (stateNext)
      EXEC: begin
        busyNext = 1'b1;
        if (opNext == OP_CLR) clearNext = 1'b1;
        if ((opNext == OP_LOAD) && (32'(argNext) < NREG)) enRegNext = NREG'(1) << argNext;
        if (opNext == OP_ALU) aluSelNext = argNext;
      end
      OUT: begin
        busyNext   = 1'b1;
        aluSelNext = argNext;
        enOutNext  = 1'b1;
      end
      HALTED: begin
        busyNext   = 1'b1;
        haltedNext = 1'b1;
      end
      default: readyNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ir       <= '0;
      repCnt   <= '0;
      repArmed <= 1'b0;
      errQ     <= 1'b0;
      clearQ   <= 1'b0;
      enRegQ   <= '0;
      aluSelQ  <= '0;
      enOutQ   <= 1'b0;
      readyQ   <= 1'b1;
      busyQ    <= 1'b0;
      haltedQ  <= 1'b0;
    end else begin
      state    <= stateNext;
      ir       <= irNext;
      repCnt   <= repCntNext;
      repArmed <= repArmedNext;
      errQ     <= errNext;
      clearQ   <= clearNext;
      enRegQ   <= enRegNext;
      aluSelQ  <= aluSelNext;
      enOutQ   <= enOutNext;
      readyQ   <= readyNext;
      busyQ    <= busyNext;
      haltedQ  <= haltedNext;
    end
  end

  assign bus.instr_ready = readyQ;
  assign bus.clear       = clearQ;
  assign bus.en_reg      = enRegQ;
  assign bus.alu_sel     = aluSelQ;
  assign bus.en_out      = enOutQ;
  assign bus.busy        = busyQ;
  assign bus.halted      = haltedQ;
  assign bus.err         = errQ;
endmodule

// File: tb/tb_seq_instruction_decoder.sv
// Directed bench for seq_instruction_decoder: per-cycle expected outputs are
// queued when an instruction is driven and popped as the DUT advances.
module tb_seq_instruction_decoder;
  logic clk;
  logic rst_n;

  seq_instruction_decoder_if #(.OPW(4), .ARGW(4), .NREG(2)) bus ();

  seq_instruction_decoder #(.OPW(4), .ARGW(4), .NREG(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       clear;
    logic [1:0] enReg;
    logic [3:0] aluSel;
    logic       enOut;
    logic       ready;
    logic       busy;
    logic       halted;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void ex(input logic c, input logic [1:0] r, input logic [3:0] a,
                             input logic o, input logic rdy, input logic bsy,
                             input logic hlt, input logic e);
    exp_t t;
    t = {c, r, a, o, rdy, bsy, hlt, e};
    q.push_back(t);
  endfunction

  function automatic void exIdle(input logic e);
    ex(1'b0, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, e);
  endfunction

  function automatic void exBusy(input logic e);
    ex(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, e);
  endfunction

  task automatic checkNow(input string tag);
    exp_t e;
    exp_t o;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    o = {bus.clear, bus.en_reg, bus.alu_sel, bus.en_out, bus.instr_ready,
         bus.busy, bus.halted, bus.err};
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed clr/en/alu/out/rdy/bsy/hlt/err=%b_%b_%h_%b_%b_%b_%b_%b expected=%b_%b_%h_%b_%b_%b_%b_%b",
             tag, o.clear, o.enReg, o.aluSel, o.enOut, o.ready, o.busy, o.halted, o.err,
             e.clear, e.enReg, e.aluSel, e.enOut, e.ready, e.busy, e.halted, e.err);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] arg);
    bus.instr_valid = 1'b1;
    bus.instr       = {op, arg};
  endtask

  // One queued expectation per clock; valid drops after the accepting edge unless held
  task automatic run(input string tag, input bit keepValid);
    int i = 0;
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      if (!keepValid) bus.instr_valid = 1'b0;
      checkNow($sformatf("%s[%0d]", tag, i));
      i++;
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    repeat (2) @(posedge clk);
    #1;
    exIdle(1'b0);
    checkNow("reset");
    rst_n = 1'b1;

    // CLR: one-cycle clear pulse, ready low for one cycle
    drive(4'd1, 4'd0);
    ex(1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exIdle(1'b0);
    run("clr", 1'b0);

    drive(4'd2, 4'd1);
    ex(1'b0, 2'b10, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exIdle(1'b0);
    run("load1", 1'b0);

    // LOAD to a non-existent register: no enable, err rises after EXEC
    drive(4'd2, 4'd3);
    exBusy(1'b0);
    exIdle(1'b1);
    run("load3", 1'b0);

    drive(4'd0, 4'd0);
    exBusy(1'b1);
    exIdle(1'b1);
    run("nop_sticky", 1'b0);

    drive(4'd3, 4'hA);
    ex(1'b0, 2'b00, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    ex(1'b0, 2'b00, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    exIdle(1'b1);
    run("aluA", 1'b0);

    drive(4'd4, 4'd2);
    exBusy(1'b1);
    exIdle(1'b1);
    run("rep2", 1'b0);
    drive(4'd2, 4'd0);
    repeat (3) ex(1'b0, 2'b01, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    exIdle(1'b1);
    run("rep_load0", 1'b0);

    drive(4'd4, 4'd1);
    exBusy(1'b1);
    exIdle(1'b1);
    run("rep1", 1'b0);
    drive(4'd3, 4'd3);
    repeat (2) begin
      ex(1'b0, 2'b00, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      ex(1'b0, 2'b00, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    exIdle(1'b1);
    run("rep_alu3", 1'b0);

    // Illegal opcode under a repeat runs as a NOP twice
    drive(4'd4, 4'd1);
    exBusy(1'b1);
    exIdle(1'b1);
    run("rep1b", 1'b0);
    drive(4'd7, 4'd0);
    exBusy(1'b1);
    exBusy(1'b1);
    exIdle(1'b1);
    run("rep_illegal", 1'b0);

    drive(4'd4, 4'd5);
    exBusy(1'b1);
    exIdle(1'b1);
    run("rep5", 1'b0);
    drive(4'd5, 4'd0);
    exBusy(1'b1);
    ex(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    run("halt", 1'b0);
    drive(4'd1, 4'd0);
    repeat (3) ex(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    run("halted_hold", 1'b1);

    rst_n = 1'b0;
    #1;
    exIdle(1'b0);
    checkNow("halt_reset");
    bus.instr_valid = 1'b0;
    rst_n = 1'b1;
    exIdle(1'b0);
    run("post_reset", 1'b0);

    // Async reset during the 2nd of 4 repeated LOADs discards the repeat
    drive(4'd4, 4'd3);
    exBusy(1'b0);
    exIdle(1'b0);
    run("rep3", 1'b0);
    drive(4'd2, 4'd1);
    repeat (2) ex(1'b0, 2'b10, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run("rep_load1", 1'b0);
    rst_n = 1'b0;
    #1;
    exIdle(1'b0);
    checkNow("mid_rep_reset");
    #1;
    rst_n = 1'b1;
    drive(4'd0, 4'd0);
    exBusy(1'b0);
    exIdle(1'b0);
    exIdle(1'b0);
    run("nop_once", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
